// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the M-stage data memory arbiter and its surroundings
// (CPU load/store path, burst DMA engine and the single-port data memory).
// The arbiter takes the slave view; whatever drives the CPU, DMA and memory
// side takes the master view.
interface dmem_arbiter_if #(
    parameter int LEN_W = 6
);
    // CPU load/store path
    logic             cpu_req;
    logic             cpu_write;
    logic [31:0]      cpu_addr;
    logic [31:0]      cpu_wdata;
    logic [31:0]      cpu_rdata;
    logic             cpu_stall;
    // burst DMA engine
    logic             dma_start;
    logic             dma_write;
    logic [31:0]      dma_base;
    logic [LEN_W-1:0] dma_len;
    logic [31:0]      dma_wdata;
    logic             dma_beat;
    logic [31:0]      dma_rdata;
    logic             dma_busy;
    logic             dma_done;
    // single-port data memory
    logic             mem_write;
    logic [31:0]      mem_address;
    logic [31:0]      mem_write_data;
    logic [31:0]      mem_read_data;

    modport slave (
        input  cpu_req, cpu_write, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dma_start, dma_write, dma_base, dma_len, dma_wdata,
        output dma_beat, dma_rdata, dma_busy, dma_done,
        output mem_write, mem_address, mem_write_data,
        input  mem_read_data
    );

    modport master (
        output cpu_req, cpu_write, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dma_start, dma_write, dma_base, dma_len, dma_wdata,
        input  dma_beat, dma_rdata, dma_busy, dma_done,
        input  mem_write, mem_address, mem_write_data,
        output mem_read_data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// M-stage data memory arbiter: the CPU has fixed priority, DMA bursts use
// idle CPU cycles, and a starvation counter forces one DMA beat (stalling
// the CPU) after WAIT_MAX consecutive denied cycles.
// Optional macro DMEM_ARB_STATS_EN adds a saturating 16-bit stall_count port.
module dmem_arbiter #(
    parameter int WAIT_MAX = 8,
    parameter int LEN_W    = 6
) (
    input  logic             clk,
    input  logic             reset,
    dmem_arbiter_if.slave    bus
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]      stall_count
`endif
);

    localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [31:0]      cur_addr;
    logic [LEN_W-1:0] remaining;
    logic [7:0]       wait_cnt;
    logic             dma_wr_q;
    logic             grant_dma;
    logic             start_ok;

    assign start_ok  = bus.dma_start && (bus.dma_len != '0);
    // Starvation override only applies while a burst is running.
    assign grant_dma = (state_q == RUN) && (!bus.cpu_req || (wait_cnt == WAIT_LIM));

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: a beat with one word left ends the burst
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = RUN;
            RUN:     if (grant_dma && (remaining == LEN_W'(1))) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Burst datapath: address, remaining count, starvation counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_addr  <= '0;
            remaining <= '0;
            wait_cnt  <= '0;
            dma_wr_q  <= 1'b0;
        end else if (state_q == IDLE) begin
            if (start_ok) begin
                cur_addr  <= bus.dma_base & 32'hFFFF_FFFC;
                remaining <= bus.dma_len;
                dma_wr_q  <= bus.dma_write;
                wait_cnt  <= '0;
            end
        end else if (state_q == RUN) begin
            if (grant_dma) begin
                cur_addr  <= cur_addr + 32'd4;
                remaining <= remaining - LEN_W'(1);
                wait_cnt  <= '0;
            end else if (bus.cpu_req && (wait_cnt != WAIT_LIM)) begin
                wait_cnt  <= wait_cnt + 8'd1;
            end
        end
    end

    // Memory port mux and handshake outputs
    always_comb begin
        bus.mem_address    = bus.cpu_addr;
        bus.mem_write_data = bus.cpu_wdata;
        bus.mem_write      = bus.cpu_req && bus.cpu_write;
        bus.cpu_stall      = 1'b0;
        bus.dma_beat       = 1'b0;
        if (grant_dma) begin
            bus.mem_address    = cur_addr;
            bus.mem_write_data = bus.dma_wdata;
            bus.mem_write      = dma_wr_q;
            bus.cpu_stall      = bus.cpu_req;
            bus.dma_beat       = 1'b1;
        end
    end

    assign bus.cpu_rdata = bus.mem_read_data;
    assign bus.dma_rdata = bus.mem_read_data;
    assign bus.dma_busy  = (state_q != IDLE);
    assign bus.dma_done  = (state_q == DONE);

`ifdef DMEM_ARB_STATS_EN
    // Count stalled CPU cycles, holding at the top value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                     stall_count <= '0;
        else if (bus.cpu_stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small word memory model.
module tb_dmem_arbiter;
    logic clk;
    logic reset;
    int   compared;
    int   mismatched;
    logic [31:0] mem [0:63];

    dmem_arbiter_if #(.LEN_W(6)) bus ();

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stall_count;
`endif

    dmem_arbiter #(.WAIT_MAX(8), .LEN_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stall_count (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // combinational-read, synchronous-write memory
    assign bus.mem_read_data = mem[bus.mem_address[7:2]];
    always @(posedge clk) if (bus.mem_write) mem[bus.mem_address[7:2]] <= bus.mem_write_data;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpu_req = 0; bus.cpu_write = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.dma_start = 0; bus.dma_write = 0; bus.dma_base = 0; bus.dma_len = 0; bus.dma_wdata = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0;
        #12;
        compared++; if (bus.dma_busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", bus.dma_busy); end
        compared++; if (bus.dma_beat !== 1'b0) begin mismatched++; $display("FAIL reset_beat got %b want 0", bus.dma_beat); end
        compared++; if (bus.dma_done !== 1'b0) begin mismatched++; $display("FAIL reset_done got %b want 0", bus.dma_done); end
        compared++; if (bus.cpu_stall !== 1'b0) begin mismatched++; $display("FAIL reset_stall got %b want 0", bus.cpu_stall); end
        compared++; if (bus.mem_write !== 1'b0) begin mismatched++; $display("FAIL reset_mem_write got %b want 0", bus.mem_write); end
`ifdef DMEM_ARB_STATS_EN
        compared++; if (stall_count !== 16'd0) begin mismatched++; $display("FAIL reset_stall_count got %0d want 0", stall_count); end
`endif
        @(negedge clk);
        reset = 1;
        tick();
    endtask

    task automatic test_cpu_only();
        bus.cpu_req = 1; bus.cpu_write = 1; bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'hDEADBEEF;
        #1;
        compared++; if (bus.mem_write !== 1'b1) begin mismatched++; $display("FAIL cpu_store_we got %b want 1", bus.mem_write); end
        compared++; if (bus.cpu_stall !== 1'b0) begin mismatched++; $display("FAIL cpu_store_stall got %b want 0", bus.cpu_stall); end
        compared++; if (bus.mem_address !== 32'h10) begin mismatched++; $display("FAIL cpu_store_addr got %h want 00000010", bus.mem_address); end
        tick();
        bus.cpu_write = 0;
        #1;
        compared++; if (bus.mem_write !== 1'b0) begin mismatched++; $display("FAIL cpu_load_we got %b want 0", bus.mem_write); end
        compared++; if (bus.cpu_rdata !== 32'hDEADBEEF) begin mismatched++; $display("FAIL cpu_load_data got %h want deadbeef", bus.cpu_rdata); end
        tick();
        idle_inputs();
    endtask

    task automatic test_dma_write();
        int busy_cycles;
        busy_cycles = 0;
        bus.dma_start = 1; bus.dma_base = 32'h20; bus.dma_len = 6'd3; bus.dma_write = 1;
        #1;
        compared++; if (bus.dma_busy !== 1'b0) begin mismatched++; $display("FAIL dmaw_busy_before got %b want 0", bus.dma_busy); end
        tick();
        bus.dma_start = 0; bus.dma_base = 0; bus.dma_len = 0;
        for (int i = 0; i < 3; i++) begin
            bus.dma_wdata = 32'hA0 + 32'(i);
            #1;
            if (bus.dma_busy === 1'b1) busy_cycles++;
            compared++; if (bus.dma_beat !== 1'b1) begin mismatched++; $display("FAIL dmaw_beat%0d got %b want 1", i, bus.dma_beat); end
            compared++; if (bus.mem_address !== 32'h20 + 32'(4*i)) begin mismatched++; $display("FAIL dmaw_addr%0d got %h want %h", i, bus.mem_address, 32'h20 + 32'(4*i)); end
            compared++; if (bus.mem_write !== 1'b1) begin mismatched++; $display("FAIL dmaw_we%0d got %b want 1", i, bus.mem_write); end
            tick();
        end
        if (bus.dma_busy === 1'b1) busy_cycles++;
        compared++; if (bus.dma_done !== 1'b1) begin mismatched++; $display("FAIL dmaw_done got %b want 1", bus.dma_done); end
        compared++; if (bus.dma_beat !== 1'b0) begin mismatched++; $display("FAIL dmaw_done_beat got %b want 0", bus.dma_beat); end
        tick();
        if (bus.dma_busy === 1'b1) busy_cycles++;
        compared++; if (bus.dma_done !== 1'b0) begin mismatched++; $display("FAIL dmaw_done_pulse got %b want 0", bus.dma_done); end
        // three beat cycles plus the DONE cycle
        compared++; if (busy_cycles !== 4) begin mismatched++; $display("FAIL dmaw_busy_cycles got %0d want 4", busy_cycles); end
        compared++; if (mem[8] !== 32'hA0 || mem[9] !== 32'hA1 || mem[10] !== 32'hA2) begin
            mismatched++; $display("FAIL dmaw_mem got %h %h %h want a0 a1 a2", mem[8], mem[9], mem[10]);
        end
        idle_inputs();
    endtask

    task automatic test_starvation();
        bus.cpu_req = 1; bus.cpu_write = 0; bus.cpu_addr = 32'h0;
        bus.dma_start = 1; bus.dma_base = 32'h20; bus.dma_len = 6'd2; bus.dma_write = 0;
        tick();
        bus.dma_start = 0;
        for (int i = 0; i < 8; i++) begin
            compared++; if (bus.dma_beat !== 1'b0 || bus.cpu_stall !== 1'b0) begin
                mismatched++; $display("FAIL starve_denied%0d got beat=%b stall=%b want 0 0", i, bus.dma_beat, bus.cpu_stall);
            end
            tick();
        end
        compared++; if (bus.dma_beat !== 1'b1 || bus.cpu_stall !== 1'b1) begin
            mismatched++; $display("FAIL starve_forced1 got beat=%b stall=%b want 1 1", bus.dma_beat, bus.cpu_stall);
        end
        compared++; if (bus.dma_rdata !== 32'hA0) begin mismatched++; $display("FAIL starve_rdata1 got %h want a0", bus.dma_rdata); end
        tick();
        compared++; if (bus.cpu_stall !== 1'b0 || bus.dma_beat !== 1'b0) begin
            mismatched++; $display("FAIL starve_resume got beat=%b stall=%b want 0 0", bus.dma_beat, bus.cpu_stall);
        end
        for (int i = 0; i < 7; i++) tick();
        compared++; if (bus.dma_beat !== 1'b0) begin mismatched++; $display("FAIL starve_early2 got %b want 0", bus.dma_beat); end
        tick();
        compared++; if (bus.dma_beat !== 1'b1 || bus.cpu_stall !== 1'b1) begin
            mismatched++; $display("FAIL starve_forced2 got beat=%b stall=%b want 1 1", bus.dma_beat, bus.cpu_stall);
        end
        compared++; if (bus.dma_rdata !== 32'hA1 || bus.mem_address !== 32'h24) begin
            mismatched++; $display("FAIL starve_beat2 got rdata=%h addr=%h want a1 00000024", bus.dma_rdata, bus.mem_address);
        end
        tick();
        compared++; if (bus.dma_done !== 1'b1) begin mismatched++; $display("FAIL starve_done got %b want 1", bus.dma_done); end
`ifdef DMEM_ARB_STATS_EN
        compared++; if (stall_count !== 16'd2) begin mismatched++; $display("FAIL starve_stall_count got %0d want 2", stall_count); end
`endif
        tick();
        idle_inputs();
    endtask

    task automatic test_align();
        bus.dma_start = 1; bus.dma_base = 32'h33; bus.dma_len = 6'd1; bus.dma_write = 0;
        tick();
        bus.dma_start = 0;
        compared++; if (bus.mem_address !== 32'h30 || bus.dma_beat !== 1'b1) begin
            mismatched++; $display("FAIL align_unaligned got addr=%h beat=%b want 00000030 1", bus.mem_address, bus.dma_beat);
        end
        tick(); tick();
        bus.dma_start = 1; bus.dma_base = 32'hFFFF_FFFC; bus.dma_len = 6'd2;
        tick();
        bus.dma_start = 0;
        compared++; if (bus.mem_address !== 32'hFFFF_FFFC) begin mismatched++; $display("FAIL align_top got %h want fffffffc", bus.mem_address); end
        tick();
        compared++; if (bus.mem_address !== 32'h0 || bus.dma_beat !== 1'b1) begin
            mismatched++; $display("FAIL align_wrap got addr=%h beat=%b want 00000000 1", bus.mem_address, bus.dma_beat);
        end
        tick(); tick();
        idle_inputs();
    endtask

    task automatic test_ignore();
        int dones;
        dones = 0;
        bus.dma_start = 1; bus.dma_base = 32'h40; bus.dma_len = 6'd0;
        tick();
        bus.dma_start = 0;
        compared++; if (bus.dma_busy !== 1'b0 || bus.dma_done !== 1'b0) begin
            mismatched++; $display("FAIL ignore_len0 got busy=%b done=%b want 0 0", bus.dma_busy, bus.dma_done);
        end
        bus.cpu_req = 1;
        bus.dma_start = 1; bus.dma_base = 32'h40; bus.dma_len = 6'd4;
        tick();
        bus.dma_base = 32'h80; bus.dma_len = 6'd1;
        tick();
        bus.dma_start = 0; bus.cpu_req = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            compared++; if (bus.dma_beat !== 1'b1 || bus.mem_address !== 32'h40 + 32'(4*i)) begin
                mismatched++; $display("FAIL ignore_beat%0d got beat=%b addr=%h want 1 %h", i, bus.dma_beat, bus.mem_address, 32'h40 + 32'(4*i));
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            if (bus.dma_done === 1'b1) dones++;
            tick();
        end
        compared++; if (dones !== 1) begin mismatched++; $display("FAIL ignore_done_count got %0d want 1", dones); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        bus.dma_start = 1; bus.dma_base = 32'h20; bus.dma_len = 6'd4; bus.dma_write = 0;
        tick();
        bus.dma_start = 0;
        tick();
        #2;
        reset = 0;
        #1;
        compared++; if (bus.dma_busy !== 1'b0 || bus.dma_beat !== 1'b0 || bus.dma_done !== 1'b0) begin
            mismatched++; $display("FAIL midreset_outs got busy=%b beat=%b done=%b want 0 0 0", bus.dma_busy, bus.dma_beat, bus.dma_done);
        end
        compared++; if (bus.cpu_stall !== 1'b0 || bus.mem_write !== 1'b0) begin
            mismatched++; $display("FAIL midreset_mem got stall=%b we=%b want 0 0", bus.cpu_stall, bus.mem_write);
        end
`ifdef DMEM_ARB_STATS_EN
        compared++; if (stall_count !== 16'd0) begin mismatched++; $display("FAIL midreset_stall_count got %0d want 0", stall_count); end
`endif
        @(negedge clk);
        reset = 1;
        tick();
        compared++; if (bus.dma_busy !== 1'b0 || bus.dma_done !== 1'b0) begin
            mismatched++; $display("FAIL midreset_after got busy=%b done=%b want 0 0", bus.dma_busy, bus.dma_done);
        end
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        reset = 1;
        idle_inputs();
        test_reset();
        test_cpu_only();
        test_dma_write();
        test_starvation();
        test_align();
        test_ignore();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
